// File: rtl/alu_mdu.sv
// alu_mdu: combinational ALU plus an iterative multiply/divide unit with HI/LO registers.
// Define ALU_MDU_DIV_EN to build the restoring divider; otherwise DIV/DIVU are accepted as no-ops.
module alu_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       alucont,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    input  logic [2:0]       md_op,
    input  logic             md_valid,
    output logic             md_ready,
    input  logic             md_flush,
    output logic             md_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;
    typedef enum logic [2:0] {
        OP_NONE  = 3'b000,
        OP_MULT  = 3'b001,
        OP_MULTU = 3'b010,
        OP_DIV   = 3'b011,
        OP_DIVU  = 3'b100,
        OP_MTHI  = 3'b101,
        OP_MTLO  = 3'b110,
        OP_RSVD  = 3'b111
    } md_op_t;

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // ---------------- ALU ----------------
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic             overflow;

    // NOTE: every signal written in an always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        b_eff    = alucont[2] ? ~b : b;
        sum      = a + b_eff + {{(WIDTH-1){1'b0}}, alucont[2]};
        overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        case (alucont[1:0])
            2'b00:   result = a & b;
            2'b01:   result = a | b;
            2'b10:   result = sum;
            default: result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ overflow};
        endcase
        zero = (result == '0);
    end

    // ---------------- MDU ----------------
    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc;      // running high product / partial remainder
    logic [WIDTH-1:0] q;        // multiplier / dividend, shifted out as result bits shift in
    logic [WIDTH-1:0] m;        // multiplicand / divisor magnitude
    logic             neg_q;
`ifdef ALU_MDU_DIV_EN
    logic             is_div;
    logic             neg_r;
    logic             div_zero;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             div_ge;
`endif

    md_op_t             op;
    logic               accept;
    logic               signed_op;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   acc_nxt;
    logic [WIDTH-1:0]   q_nxt;
    logic [WIDTH-1:0]   hi_fix;
    logic [WIDTH-1:0]   lo_fix;

    assign md_ready = (state == S_IDLE);

    always_comb begin
        op        = md_op_t'(md_op);
        accept    = md_valid && (state == S_IDLE) && (op != OP_NONE) && (op != OP_RSVD);
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        a_neg     = signed_op && a[WIDTH-1];
        b_neg     = signed_op && b[WIDTH-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;

        mul_sum = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
        acc_nxt = mul_sum[WIDTH:1];
        q_nxt   = {mul_sum[0], q[WIDTH-1:1]};
        prod    = neg_q ? -{acc, q} : {acc, q};
        hi_fix  = prod[2*WIDTH-1:WIDTH];
        lo_fix  = prod[WIDTH-1:0];
`ifdef ALU_MDU_DIV_EN
        shifted = {acc, q[WIDTH-1]};
        div_ge  = shifted >= {1'b0, m};
        diff    = shifted[WIDTH-1:0] - m;
        if (is_div) begin
            acc_nxt = div_ge ? diff : shifted[WIDTH-1:0];
            q_nxt   = {q[WIDTH-2:0], div_ge};
            // A zero divisor leaves the dividend magnitude in acc, so sign fix-up yields hi = a.
            hi_fix  = neg_r ? -acc : acc;
            lo_fix  = div_zero ? '1 : (neg_q ? -q : q);
        end
`endif
    end

    // NOTE: all state here is plain registers updated with non-blocking assignments under a synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            count   <= '0;
            acc     <= '0;
            q       <= '0;
            m       <= '0;
            neg_q   <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            md_done <= 1'b0;
`ifdef ALU_MDU_DIV_EN
            is_div   <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
`endif
        end else begin
            md_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        count <= '0;
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                acc   <= '0;
                                q     <= b_mag;
                                m     <= a_mag;
                                neg_q <= a_neg ^ b_neg;
`ifdef ALU_MDU_DIV_EN
                                is_div <= 1'b0;
`endif
                                state <= S_RUN;
                            end
`ifdef ALU_MDU_DIV_EN
                            OP_DIV, OP_DIVU: begin
                                acc      <= '0;
                                q        <= a_mag;
                                m        <= b_mag;
                                neg_q    <= a_neg ^ b_neg;
                                neg_r    <= a_neg;
                                div_zero <= (b == '0);
                                is_div   <= 1'b1;
                                state    <= S_RUN;
                            end
`endif
                            OP_MTHI: hi <= a;
                            OP_MTLO: lo <= a;
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    if (md_flush) begin
                        state <= S_IDLE;
                    end else begin
                        acc   <= acc_nxt;
                        q     <= q_nxt;
                        count <= count + CW'(1);
                        if (count == LAST) state <= S_FIX;
                    end
                end
                S_FIX: begin
                    state <= S_IDLE;
                    if (!md_flush) begin
                        hi      <= hi_fix;
                        lo      <= lo_fix;
                        md_done <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed, table-driven bench for alu_mdu (WIDTH=32); divider expectations
// follow whether ALU_MDU_DIV_EN is defined for the build.
module tb_alu_mdu;

    localparam int W = 32;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] a, b, result, hi, lo;
    logic [2:0]   alucont, md_op;
    logic         zero, md_valid, md_ready, md_flush, md_done;

    alu_mdu #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .a(a), .b(b), .alucont(alucont),
        .result(result), .zero(zero), .md_op(md_op), .md_valid(md_valid),
        .md_ready(md_ready), .md_flush(md_flush), .md_done(md_done),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   alucont;
        logic [W-1:0] a, b, result;
        logic         zero;
    } alu_vec_t;

    typedef struct {
        string        name;
        logic [2:0]   op;
        logic [W-1:0] a, b, hi, lo;
    } md_vec_t;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Called between edges; returns 1 time unit after the accept edge with operands scrambled.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] oa, input logic [W-1:0] ob);
        md_op = op; a = oa; b = ob; md_valid = 1'b1;
        @(posedge clk); #1;
        md_valid = 1'b0; md_op = 3'b000; a = $urandom; b = $urandom;
    endtask

    task automatic mt(input logic [2:0] op, input logic [W-1:0] val);
        md_op = op; a = val; md_valid = 1'b1;
        @(posedge clk); #1;
        md_valid = 1'b0; md_op = 3'b000;
    endtask

    task automatic run_op(input md_vec_t v);
        int n;
        int ready_busy;
        bit got;
        n = 0; ready_busy = 0; got = 1'b0;
        issue(v.op, v.a, v.b);
        while (!got && n < 100) begin
            @(posedge clk); #1; n++;
            if (md_done) got = 1'b1;
            else if (md_ready) ready_busy++;
        end
        check({v.name, "_latency"}, 64'(n), 64'(W + 1));
        check({v.name, "_ready_while_busy"}, 64'(ready_busy), 64'd0);
        check({v.name, "_hi"}, 64'(hi), 64'(v.hi));
        check({v.name, "_lo"}, 64'(lo), 64'(v.lo));
        check({v.name, "_ready_at_done"}, 64'(md_ready), 64'd1);
        @(posedge clk); #1;
        check({v.name, "_done_one_cycle"}, 64'(md_done), 64'd0);
    endtask

    // Watches a number of cycles and reports how many had md_done high.
    task automatic count_done(input int cycles, output int n_done);
        n_done = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (md_done) n_done++;
        end
    endtask

    alu_vec_t alu_tab[13];
    md_vec_t  mul_tab[6];
`ifdef ALU_MDU_DIV_EN
    md_vec_t  div_tab[7];
`endif

    initial begin
        #500000;
        $display("FAIL global_timeout: got timeout, want completion");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int n;
        int n_done;
        int ready_busy;
        bit got;

        alu_tab[0]  = '{3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0};
        alu_tab[1]  = '{3'b100, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0};
        alu_tab[2]  = '{3'b001, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b0};
        alu_tab[3]  = '{3'b101, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1};
        alu_tab[4]  = '{3'b010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1};
        alu_tab[5]  = '{3'b010, 32'h12345678, 32'h11111111, 32'h23456789, 1'b0};
        alu_tab[6]  = '{3'b110, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0};
        alu_tab[7]  = '{3'b110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0};
        alu_tab[8]  = '{3'b111, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b1};
        alu_tab[9]  = '{3'b111, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0};
        alu_tab[10] = '{3'b111, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        alu_tab[11] = '{3'b111, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1};
        alu_tab[12] = '{3'b111, 32'h00000003, 32'hFFFFFFFE, 32'h00000000, 1'b1};

        mul_tab[0] = '{"mult_neg2x3",   OP_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
        mul_tab[1] = '{"multu_max",     OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        mul_tab[2] = '{"mult_minxmin",  OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        mul_tab[3] = '{"mult_maxxneg1", OP_MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001};
        mul_tab[4] = '{"multu_x0",      OP_MULTU, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000};
        mul_tab[5] = '{"mult_3x5",      OP_MULT,  32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F};
`ifdef ALU_MDU_DIV_EN
        div_tab[0] = '{"div_m7_2",     OP_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        div_tab[1] = '{"divu_7_0",     OP_DIVU, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
        div_tab[2] = '{"div_min_m1",   OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        div_tab[3] = '{"div_7_m2",     OP_DIV,  32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        div_tab[4] = '{"divu_100_7",   OP_DIVU, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
        div_tab[5] = '{"div_m5_0",     OP_DIV,  32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
        div_tab[6] = '{"divu_max_2",   OP_DIVU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'h7FFFFFFF};
`endif

        // Reset, with the ALU exercised while reset is held.
        reset_n = 1'b0; md_valid = 1'b0; md_op = 3'b000; md_flush = 1'b0;
        alucont = 3'b010; a = 32'd5; b = 32'd6;
        #1;
        check("alu_in_reset", 64'(result), 64'd11);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_ready", 64'(md_ready), 64'd1);
        check("reset_done", 64'(md_done), 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            alucont = alu_tab[i].alucont; a = alu_tab[i].a; b = alu_tab[i].b;
            #1;
            check($sformatf("alu%0d_result", i), 64'(result), 64'(alu_tab[i].result));
            check($sformatf("alu%0d_zero", i), 64'(zero), 64'(alu_tab[i].zero));
        end
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) run_op(mul_tab[i]);

        // MTHI presented while busy must be ignored.
        issue(OP_MULT, 32'hFFFFFFFE, 32'h00000003);
        repeat (3) @(posedge clk);
        #1;
        md_valid = 1'b1; md_op = OP_MTHI; a = 32'h12345678;
        @(posedge clk); #1;
        md_valid = 1'b0; md_op = 3'b000;
        n = 4; got = 1'b0;
        while (!got && n < 100) begin
            @(posedge clk); #1; n++;
            if (md_done) got = 1'b1;
        end
        check("busy_mthi_latency", 64'(n), 64'(W + 1));
        check("busy_mthi_hi", 64'(hi), 64'hFFFFFFFF);
        check("busy_mthi_lo", 64'(lo), 64'hFFFFFFFA);

        // MTHI/MTLO in IDLE; md_flush in IDLE has no effect.
        mt(OP_MTHI, 32'h12345678);
        check("mthi_hi", 64'(hi), 64'h12345678);
        check("mthi_lo_kept", 64'(lo), 64'hFFFFFFFA);
        check("mthi_no_done", 64'(md_done), 64'd0);
        check("mthi_ready", 64'(md_ready), 64'd1);
        md_flush = 1'b1;
        mt(OP_MTLO, 32'hCAFEF00D);
        md_flush = 1'b0;
        check("mtlo_flush_idle_lo", 64'(lo), 64'hCAFEF00D);
        count_done(3, n_done);
        check("mt_no_done_after", 64'(n_done), 64'd0);

        // Reserved op code is not accepted.
        mt(3'b111, 32'hDEADBEEF);
        check("rsvd_hi", 64'(hi), 64'h12345678);
        check("rsvd_lo", 64'(lo), 64'hCAFEF00D);
        check("rsvd_ready", 64'(md_ready), 64'd1);

        // Flush at E10 during RUN; ALU still live mid-operation.
        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (9) @(posedge clk);
        #1;
        md_flush = 1'b1; alucont = 3'b010; a = 32'd1; b = 32'd2;
        #1;
        check("alu_while_busy", 64'(result), 64'd3);
        check("busy_ready_low", 64'(md_ready), 64'd0);
        @(posedge clk); #1;
        md_flush = 1'b0;
        check("flush_run_ready", 64'(md_ready), 64'd1);
        check("flush_run_hi", 64'(hi), 64'h12345678);
        check("flush_run_lo", 64'(lo), 64'hCAFEF00D);
        count_done(40, n_done);
        check("flush_run_no_done", 64'(n_done), 64'd0);

        // Reset at E10 during RUN.
        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (9) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("reset_run_hi", 64'(hi), 64'd0);
        check("reset_run_lo", 64'(lo), 64'd0);
        check("reset_run_ready", 64'(md_ready), 64'd1);
        count_done(40, n_done);
        check("reset_run_no_done", 64'(n_done), 64'd0);

        // Flush on the FIX edge suppresses the write and the done pulse.
        mt(OP_MTHI, 32'h11111111);
        mt(OP_MTLO, 32'h22222222);
        issue(OP_MULT, 32'd3, 32'd3);
        repeat (W) @(posedge clk);
        #1;
        md_flush = 1'b1;
        @(posedge clk); #1;
        md_flush = 1'b0;
        check("flush_fix_done", 64'(md_done), 64'd0);
        check("flush_fix_hi", 64'(hi), 64'h11111111);
        check("flush_fix_lo", 64'(lo), 64'h22222222);
        check("flush_fix_ready", 64'(md_ready), 64'd1);
        run_op('{"mult_after_flush", OP_MULT, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 32'h0000000F});

`ifdef ALU_MDU_DIV_EN
        for (int i = 0; i < 7; i++) run_op(div_tab[i]);
`else
        // Without the divider, DIV/DIVU are single-cycle no-ops.
        mt(OP_MTHI, 32'hAAAA5555);
        mt(OP_MTLO, 32'h5555AAAA);
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
        check("nodiv_ready", 64'(md_ready), 64'd1);
        ready_busy = 0; n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (md_done) n_done++;
            if (!md_ready) ready_busy++;
        end
        check("nodiv_no_done", 64'(n_done), 64'd0);
        check("nodiv_ready_stays", 64'(ready_busy), 64'd0);
        check("nodiv_hi", 64'(hi), 64'hAAAA5555);
        check("nodiv_lo", 64'(lo), 64'h5555AAAA);
        issue(OP_DIVU, 32'd7, 32'd0);
        check("nodivu_ready", 64'(md_ready), 64'd1);
        check("nodivu_hi", 64'(hi), 64'hAAAA5555);
        check("nodivu_lo", 64'(lo), 64'h5555AAAA);
        run_op(mul_tab[0]);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (legal 8..64, even).
REQ-002 SHALL have port clk  input  1  rising-edge clock, sole clock.
REQ-003 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports a, b  input  WIDTH  operands, shared by ALU and MDU.
REQ-005 SHALL have port alucont  input  3  ALU op: [2] invert b plus carry-in 1; [1:0] 00 AND, 01 OR, 10 SUM, 11 SLT.
REQ-006 SHALL have port result  output  WIDTH  combinational ALU result.
REQ-007 SHALL have port zero  output  1  high when result == 0.
REQ-008 SHALL have port md_op  input  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 none.
REQ-009 SHALL have port md_valid  input  1  request qualifier.
REQ-010 SHALL have port md_ready  output  1  high when idle and able to accept.
REQ-011 SHALL have port md_flush  input  1  abort in-flight MULT/DIV.
REQ-012 SHALL have port md_done  output  1  one-cycle pulse, HI/LO updated by MULT/DIV.
REQ-013 SHALL have ports hi, lo  output  WIDTH  registered HI/LO contents.

Function
REQ-014 AND/OR SHALL ignore alucont[2]; SUM = a + (alucont[2] ? ~b : b) + alucont[2], modulo 2^WIDTH.
REQ-015 SLT SHALL give 1 (zero-extended) when a < b signed, correct under subtraction overflow (sum MSB XOR signed overflow), with alucont[2]=1.
REQ-016 Accept SHALL occur at an edge with md_valid && md_ready && md_op not none; md_valid otherwise ignored, including while busy.
REQ-017 FSM states IDLE, RUN, FIX; IDLE->RUN on MULT/DIV accept; RUN->FIX after exactly WIDTH iterations; FIX->IDLE always.
REQ-018 md_ready SHALL be high only in IDLE.
REQ-019 Accept SHALL latch operand magnitudes (signed ops) or raw values (unsigned ops) and result sign flags; later a/b changes have no effect.
REQ-020 MULT/MULTU: shift-add, one bit per RUN cycle; {hi,lo} = full 2*WIDTH-bit product.
REQ-021 DIV/DIVU: restoring, one quotient bit per RUN cycle; lo = quotient truncated toward zero, hi = remainder with sign of dividend.
REQ-022 FIX edge SHALL apply sign correction, write hi/lo and set md_done; hi/lo new and md_done=1 together in the cycle after the FIX edge, md_ready=1 in that same cycle.
REQ-023 Latency: accept edge E0, hi/lo written at edge E0+WIDTH+1.
REQ-024 Divide by zero: hi = a, lo = all ones; same latency, md_done pulses.
REQ-025 Signed MIN / -1: lo = MIN, hi = 0; no exception.
REQ-026 MTHI/MTLO: write hi resp. lo with a at accept edge; stay IDLE; md_done not asserted.
REQ-027 md_flush high at an edge in RUN or FIX: next state IDLE, hi/lo unchanged, md_done not asserted; md_flush in IDLE no effect; md_flush has priority over accept.
REQ-028 md_done SHALL be low in every cycle other than the one in REQ-022.
REQ-029 The ALU path SHALL be independent of MDU state.

Reset
REQ-030 reset_n low at an edge SHALL force IDLE, hi=0, lo=0, md_done=0, iteration counter 0, in all states including mid-RUN.
REQ-031 After reset: md_ready=1; result/zero follow inputs combinationally regardless of reset.
REQ-032 Reset SHALL have priority over md_flush and accept.

Configuration
REQ-033 Macro ALU_MDU_DIV_EN defined: divider per REQ-021/024/025 compiled in.
REQ-034 Macro ALU_MDU_DIV_EN undefined: no divider logic; DIV/DIVU accepted as single-cycle no-ops, hi/lo unchanged, stay IDLE, md_done not asserted; MULT/MTHI/MTLO unaffected.

Verification
REQ-035 WIDTH=32, alucont=111, a=0x7FFFFFFF, b=0x80000000 -> result=0, zero=1; a=0x80000000, b=1 -> result=1.
REQ-036 MULT a=0xFFFFFFFE (-2), b=3 at E0 -> md_done after E33, hi=0xFFFFFFFF, lo=0xFFFFFFFA; md_ready low until then.
REQ-037 DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=0 -> hi=7, lo=0xFFFFFFFF.
REQ-038 MULTU a=b=0xFFFFFFFF, md_flush at E10 -> IDLE at cycle after E10, hi/lo unchanged, no md_done; reset_n low at E10 instead -> hi=lo=0.
REQ-039 MTHI a=0x12345678 while busy ignored; in IDLE -> hi=0x12345678 next cycle, no md_done; without ALU_MDU_DIV_EN, DIV -> hi/lo unchanged, md_ready stays 1.
